// File: rtl/sqrt_ctrl_pkg.sv
// Shared definitions for the 8-bit integer square-root unit: controller state
// encoding, default iteration guard and datapath register widths.
package sqrt_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_LOAD   = 3'd2,
        S_TEST   = 3'd3,
        S_UPDATE = 3'd4,
        S_OUTLD  = 3'd5,
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_e;

    localparam int MAX_ITER_DEF = 16;
    localparam int ITER_W_DEF   = 5;

    localparam int A_W    = 8;
    localparam int SQ_W   = 9;
    localparam int DEL_W  = 5;
    localparam int ROOT_W = 4;

endpackage

// File: rtl/sqrt_ctrl.sv
// Sequencer for the square-root datapath: go/ready start handshake, Moore
// strobes per state, lteflg-driven iteration with a runaway guard, done/err held until ack.
module sqrt_ctrl
    import sqrt_ctrl_pkg::*;
#(
    parameter int MAX_ITER = MAX_ITER_DEF,
    parameter int ITER_W   = ITER_W_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              go,
    output logic              ready,
    input  logic              lteflg,
    input  logic              ack,
    output logic              dp_init,
    output logic              ald,
    output logic              sqld,
    output logic              dld,
    output logic              outld,
    output logic              done,
    output logic              err,
    output logic [ITER_W-1:0] iter
);

    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);
    localparam logic [ITER_W-1:0] ITER_ONE   = ITER_W'(1);

    state_e            state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;

    logic dp_init_s, ald_s, sqld_s, dld_s, outld_s;

    // State register and iteration counter.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        case (state_q)
            S_IDLE:   if (go) state_d = S_INIT;
            S_INIT: begin
                iter_d  = '0;
                state_d = S_LOAD;
            end
            S_LOAD:   state_d = S_TEST;
            S_TEST: begin
                if (!lteflg)                state_d = S_OUTLD;
                else if (iter_q < ITER_LIMIT) state_d = S_UPDATE;
                else                        state_d = S_ERROR;
            end
            S_UPDATE: begin
                // Saturate so a mis-sized ITER_W can never wrap back under the limit.
                if (iter_q != '1) iter_d = iter_q + ITER_ONE;
                state_d = S_TEST;
            end
            S_OUTLD:  state_d = S_DONE;
            S_DONE:   if (ack) state_d = S_IDLE;
            S_ERROR:  if (ack) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore output decode.
    always_comb begin
        ready     = 1'b0;
        dp_init_s = 1'b0;
        ald_s     = 1'b0;
        sqld_s    = 1'b0;
        dld_s     = 1'b0;
        outld_s   = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            S_IDLE:   ready     = 1'b1;
            S_INIT:   dp_init_s = 1'b1;
            S_LOAD:   ald_s     = 1'b1;
            S_UPDATE: begin
                sqld_s = 1'b1;
                dld_s  = 1'b1;
            end
            S_OUTLD:  outld_s   = 1'b1;
            S_DONE:   done      = 1'b1;
            S_ERROR:  err       = 1'b1;
            default:  ;
        endcase
    end

    // Strobes are masked during a reset cycle so an aborted run never touches the datapath.
    assign dp_init = dp_init_s & clr;
    assign ald     = ald_s     & clr;
    assign sqld    = sqld_s    & clr;
    assign dld     = dld_s     & clr;
    assign outld   = outld_s   & clr;
    assign iter    = iter_q;

endmodule

// File: tb/tb_sqrt_ctrl.sv
// Bench for sqrt_ctrl with an attached behavioural datapath; expected roots,
// latencies and pass counts come from plain integer square-root arithmetic.
module tb_sqrt_ctrl;

    logic       clk = 1'b0;
    logic       clr, go, ack, lteflg;
    logic       ready, dp_init, ald, sqld, dld, outld, done, err;
    logic [4:0] iter;

    always #5 clk = ~clk;

    sqrt_ctrl dut (
        .clk(clk), .clr(clr), .go(go), .ready(ready), .lteflg(lteflg), .ack(ack),
        .dp_init(dp_init), .ald(ald), .sqld(sqld), .dld(dld), .outld(outld),
        .done(done), .err(err), .iter(iter)
    );

    // Datapath model driven by the strobes.
    logic [7:0] sw, a_r;
    logic [8:0] sq_r;
    logic [4:0] del_r;
    logic [3:0] root_r;
    logic       stuck;

    always @(posedge clk) begin
        if (dp_init) begin
            a_r <= 8'd0; sq_r <= 9'd1; del_r <= 5'd3; root_r <= 4'd0;
        end
        if (ald)   a_r   <= sw;
        if (sqld)  sq_r  <= sq_r + {4'd0, del_r};
        if (dld)   del_r <= del_r + 5'd2;
        if (outld) root_r <= del_r[4:1] - 4'd1;
    end
    assign lteflg = stuck ? 1'b1 : (sq_r <= {1'b0, a_r});

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // One run from IDLE up to the first done/err cycle (no ack).
    int r_lat, r_upd, r_order_ok;
    task automatic run(input int a);
        int cyc;
        @(negedge clk);
        sw = 8'(a); go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        cyc = 0; r_upd = 0; r_order_ok = 1;
        while (!done && !err && cyc < 200) begin
            if (cyc == 0 && !dp_init) r_order_ok = 0;
            if (cyc == 1 && !ald) r_order_ok = 0;
            if (sqld != dld) r_order_ok = 0;
            if (sqld) begin
                r_upd++;
                if (cyc % 2 != 1 || cyc < 3) r_order_ok = 0;
            end
            if (outld && !lteflg && cyc < 2) r_order_ok = 0;
            @(negedge clk);
            cyc++;
        end
        r_lat = cyc;
        if (cyc >= 200) check("timeout", 0, 1);
    endtask

    task automatic do_ack;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("ready_after_ack", int'(ready), 1);
        check("done_cleared", int'(done), 0);
    endtask

    typedef struct { int a; int root; int lat; int it; } vec_t;
    vec_t vecs[6];

    initial begin
        clr = 1'b0; go = 1'b0; ack = 1'b0; sw = 8'd0; stuck = 1'b0;
        vecs[0] = '{16, 4, 12, 4};
        vecs[1] = '{0, 0, 4, 0};
        vecs[2] = '{255, 15, 34, 15};
        vecs[3] = '{1, 1, 6, 1};
        vecs[4] = '{9, 3, 10, 3};
        vecs[5] = '{15, 3, 10, 3};

        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        check("rst_ready", int'(ready), 1);
        check("rst_flags", int'({done, err}), 0);
        check("rst_strobes", int'({dp_init, ald, sqld, dld, outld}), 0);
        check("rst_iter", int'(iter), 0);

        foreach (vecs[i]) begin
            run(vecs[i].a);
            check($sformatf("vec%0d_done", i), int'(done), 1);
            check($sformatf("vec%0d_lat", i), r_lat, vecs[i].lat);
            check($sformatf("vec%0d_root", i), int'(root_r), vecs[i].root);
            check($sformatf("vec%0d_iter", i), int'(iter), vecs[i].it);
            check($sformatf("vec%0d_upd", i), r_upd, vecs[i].it);
            check($sformatf("vec%0d_order", i), r_order_ok, 1);
            do_ack();
        end

        for (int i = 0; i < 20; i++) begin
            int a, k;
            a = int'($urandom_range(0, 255));
            k = isqrt(a);
            run(a);
            check($sformatf("rnd_a%0d_lat", a), r_lat, 4 + 2 * k);
            check($sformatf("rnd_a%0d_root", a), int'(root_r), k);
            check($sformatf("rnd_a%0d_iter", a), int'(iter), k);
            do_ack();
        end

        // lteflg stuck high: guard trips after MAX_ITER passes.
        stuck = 1'b1;
        run(50);
        check("stuck_err", int'(err), 1);
        check("stuck_done", int'(done), 0);
        check("stuck_upd", r_upd, 16);
        check("stuck_lat", r_lat, 4 + 2 * 16 - 1);
        check("stuck_iter", int'(iter), 16);
        repeat (3) @(negedge clk);
        check("stuck_err_held", int'(err), 1);
        check("stuck_no_strobe", int'({dp_init, ald, sqld, dld, outld}), 0);
        stuck = 1'b0;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("stuck_ack_ready", int'(ready), 1);
        check("stuck_err_clr", int'(err), 0);

        // Reset in the middle of an UPDATE pass.
        begin
            int t = 0;
            sw = 8'd200; go = 1'b1;
            @(negedge clk);
            go = 1'b0;
            while (!sqld && t < 20) begin @(negedge clk); t++; end
            check("midrst_reach_update", int'(sqld), 1);
            clr = 1'b0;
            #1;
            check("midrst_strobes_masked", int'({dp_init, ald, sqld, dld, outld}), 0);
            @(negedge clk);
            check("midrst_ready", int'(ready), 1);
            check("midrst_strobes", int'({dp_init, ald, sqld, dld, outld}), 0);
            check("midrst_iter", int'(iter), 0);
            clr = 1'b1;
            run(9);
            check("midrst_root", int'(root_r), 3);
        end

        // go together with ack in DONE is dropped; go held one more cycle starts a run.
        go = 1'b1; ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("goack_idle", int'(ready), 1);
        check("goack_no_init", int'(dp_init), 0);
        @(negedge clk);
        go = 1'b0;
        check("goheld_init", int'(dp_init), 1);
        check("goheld_not_ready", int'(ready), 0);
        begin
            int t = 0;
            while (!done && t < 50) begin @(negedge clk); t++; end
            check("goheld_done", int'(done), 1);
            check("goheld_root", int'(root_r), 3);
        end
        do_ack();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
